snn_image_sequencer: RTL and testbench

- Top-level sequencer for one SNN presentation run. Fetches each image and label from the image loader.
- Steps the neuron core through num_tu time units per image and drives the spike-count/decision block (coring, TU_incre, done_core_img, deciding, train_test_classify, test_label).
- Waits for valid_deciding before advancing to the next image. Sits between the run controller (start/abort) and the core/decision datapath.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/snn_image_sequencer.sv | 176 +++++++++++++++++
 tb/tb_snn_image_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN presentation sequencer: mode encodings,
// sequencer states and default widths.
package snn_pkg;

    localparam logic [1:0] MODE_TRAIN    = 2'b01;
    localparam logic [1:0] MODE_TEST     = 2'b10;
    localparam logic [1:0] MODE_CLASSIFY = 2'b11;

    localparam int DEF_N           = 8;
    localparam int DEF_IMG_W       = 16;
    localparam int DEF_TU_W        = 16;
    localparam int DEF_DEC_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        WAIT_STEP,
        DECIDE
    } seq_state_t;

    // Mode 00 has no meaning of its own and runs as training.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_TEST || m == MODE_CLASSIFY) ? m : MODE_TRAIN;
    endfunction

endpackage

// File: rtl/snn_image_sequencer.sv
// Sequences one SNN presentation run: load each image, step the core through
// num_tu time units, then wait (with a watchdog) for the decision block.
module snn_image_sequencer
    import snn_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int TU_W        = DEF_TU_W,
    parameter int DEC_TIMEOUT = DEF_DEC_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [IMG_W-1:0] num_images,
    input  logic [TU_W-1:0]  num_tu,
    output logic             img_req,
    output logic [IMG_W-1:0] img_addr,
    input  logic             img_ack,
    input  logic [7:0]       label_in,
    output logic             step_go,
    input  logic             step_done,
    input  logic             valid_deciding,
    output logic             coring,
    output logic             TU_incre,
    output logic             done_core_img,
    output logic             deciding,
    output logic [1:0]       train_test_classify,
    output logic [7:0]       test_label,
    output logic             busy,
    output logic             run_done,
    output logic             timeout_err,
    output logic [IMG_W-1:0] img_count
);

    localparam int WD_W = (DEC_TIMEOUT > 1) ? $clog2(DEC_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DEC_TIMEOUT - 1);

    // The neuron count only sizes the shared datapath; nothing here uses it.
    if (N < 1) begin : g_n_invalid
    end

    seq_state_t       state_reg, state_next;
    logic [TU_W-1:0]  num_tu_reg, tu_cnt_reg;
    logic [IMG_W-1:0] num_images_reg, img_addr_reg, img_count_reg;
    logic [WD_W-1:0]  wd_cnt_reg;
    logic [1:0]       mode_reg;
    logic [7:0]       label_reg;
    logic             img_req_reg, step_go_reg, coring_reg, tu_incre_reg;
    logic             done_img_reg, deciding_reg, busy_reg, run_done_reg, timeout_reg;

    logic start_ok, last_tu, last_img, wd_expired, dec_exit;

    assign start_ok   = start && (num_images != '0) && (num_tu != '0);
    assign last_tu    = (tu_cnt_reg == num_tu_reg - TU_W'(1));
    assign last_img   = (img_addr_reg == num_images_reg - IMG_W'(1));
    assign wd_expired = (wd_cnt_reg == WD_LAST);
    assign dec_exit   = valid_deciding || wd_expired;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:      if (start_ok) state_next = LOAD;
                LOAD:      if (img_ack) state_next = STEP;
                STEP:      state_next = WAIT_STEP;
                WAIT_STEP: if (step_done) state_next = last_tu ? DECIDE : STEP;
                DECIDE:    if (dec_exit) state_next = last_img ? IDLE : LOAD;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Registered outputs and datapath counters, decoded from the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_tu_reg     <= '0;
            num_images_reg <= '0;
            tu_cnt_reg     <= '0;
            img_addr_reg   <= '0;
            img_count_reg  <= '0;
            wd_cnt_reg     <= '0;
            mode_reg       <= '0;
            label_reg      <= '0;
            img_req_reg    <= 1'b0;
            step_go_reg    <= 1'b0;
            coring_reg     <= 1'b0;
            tu_incre_reg   <= 1'b0;
            done_img_reg   <= 1'b0;
            deciding_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            run_done_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            step_go_reg  <= 1'b0;
            tu_incre_reg <= 1'b0;
            done_img_reg <= 1'b0;
            run_done_reg <= 1'b0;
            busy_reg     <= (state_next != IDLE);
            if (abort) begin
                img_req_reg  <= 1'b0;
                coring_reg   <= 1'b0;
                deciding_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: if (start_ok) begin
                        mode_reg       <= norm_mode(mode);
                        num_images_reg <= num_images;
                        num_tu_reg     <= num_tu;
                        img_addr_reg   <= '0;
                        img_count_reg  <= '0;
                        timeout_reg    <= 1'b0;
                        img_req_reg    <= 1'b1;
                    end
                    LOAD: if (img_ack) begin
                        label_reg   <= label_in;
                        img_req_reg <= 1'b0;
                        tu_cnt_reg  <= '0;
                    end
                    STEP: begin
                        step_go_reg <= 1'b1;
                        coring_reg  <= 1'b1;
                    end
                    WAIT_STEP: if (step_done) begin
                        tu_incre_reg <= 1'b1;
                        if (last_tu) begin
                            done_img_reg <= 1'b1;
                            deciding_reg <= 1'b1;
                            wd_cnt_reg   <= '0;
                        end else begin
                            tu_cnt_reg <= tu_cnt_reg + TU_W'(1);
                        end
                    end
                    DECIDE: if (dec_exit) begin
                        deciding_reg  <= 1'b0;
                        coring_reg    <= 1'b0;
                        img_count_reg <= img_count_reg + IMG_W'(1);
                        if (!valid_deciding) timeout_reg <= 1'b1;
                        if (last_img) begin
                            run_done_reg <= 1'b1;
                        end else begin
                            img_addr_reg <= img_addr_reg + IMG_W'(1);
                            img_req_reg  <= 1'b1;
                        end
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign img_req             = img_req_reg;
    assign img_addr            = img_addr_reg;
    assign step_go             = step_go_reg;
    assign coring              = coring_reg;
    assign TU_incre            = tu_incre_reg;
    assign done_core_img       = done_img_reg;
    assign deciding            = deciding_reg;
    assign train_test_classify = mode_reg;
    assign test_label          = label_reg;
    assign busy                = busy_reg;
    assign run_done            = run_done_reg;
    assign timeout_err         = timeout_reg;
    assign img_count           = img_count_reg;

endmodule

// File: tb/tb_snn_image_sequencer.sv
// Scoreboard bench for snn_image_sequencer: stimulus queues expected TU/run
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_snn_image_sequencer;
    import snn_pkg::*;

    localparam int IMG_W = 16;
    localparam int TU_W  = 16;

    logic             clk, rst, start, abort;
    logic [1:0]       mode;
    logic [IMG_W-1:0] num_images;
    logic [TU_W-1:0]  num_tu;
    logic             img_req, img_ack, step_go, step_done, valid_deciding;
    logic [IMG_W-1:0] img_addr, img_count;
    logic [7:0]       label_in, test_label;
    logic             coring, TU_incre, done_core_img, deciding, busy, run_done, timeout_err;
    logic [1:0]       train_test_classify;
    logic             sd_auto, sd_force, vd_auto, vd_force;

    assign step_done      = sd_auto | sd_force;
    assign valid_deciding = vd_auto | vd_force;

    snn_image_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .num_images(num_images), .num_tu(num_tu),
        .img_req(img_req), .img_addr(img_addr), .img_ack(img_ack), .label_in(label_in),
        .step_go(step_go), .step_done(step_done), .valid_deciding(valid_deciding),
        .coring(coring), .TU_incre(TU_incre), .done_core_img(done_core_img),
        .deciding(deciding), .train_test_classify(train_test_classify),
        .test_label(test_label), .busy(busy), .run_done(run_done),
        .timeout_err(timeout_err), .img_count(img_count)
    );

    typedef struct {
        bit               is_run;
        bit               done;
        logic [7:0]       label;
        logic [IMG_W-1:0] count;
        bit               terr;
        logic [1:0]       mode;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] label_tab [0:3];
    int         dec_delay;
    bit         loader_en, core_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {13'd0, img_req, img_addr, step_go, coring, TU_incre, done_core_img, deciding,
                train_test_classify, test_label, busy, run_done, timeout_err, img_count};
    endfunction

    task automatic push_tu(input bit done, input logic [7:0] label);
        ev_t e;
        e = '{is_run: 1'b0, done: done, label: label, count: '0, terr: 1'b0, mode: 2'b00};
        exp_q.push_back(e);
    endtask

    task automatic push_run(input logic [IMG_W-1:0] count, input bit terr, input logic [1:0] m);
        ev_t e;
        e = '{is_run: 1'b1, done: 1'b0, label: 8'h00, count: count, terr: terr, mode: m};
        exp_q.push_back(e);
    endtask

    task automatic start_run(input logic [1:0] m, input logic [IMG_W-1:0] ni, input logic [TU_W-1:0] nt);
        mode = m; num_images = ni; num_tu = nt; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'b00; num_images = '0; num_tu = '0;
    endtask

    task automatic wait_run_done(input string name, input int budget);
        int k = 0;
        while (!run_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!run_done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: run_done not seen within %0d cycles, required run_done=1", name, budget);
        end
    endtask

    task automatic wait_deciding(input string name, input int budget);
        int k = 0;
        while (!deciding && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!deciding) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: deciding not seen within %0d cycles, required deciding=1", name, budget);
        end
    endtask

    // Image loader: acks two cycles after it sees img_req.
    initial begin
        int ld_cnt = 0;
        img_ack = 1'b0; label_in = 8'h00;
        forever begin
            @(posedge clk); #1;
            img_ack = 1'b0;
            if (img_req && loader_en) begin
                ld_cnt++;
                if (ld_cnt == 2) begin
                    img_ack  = 1'b1;
                    label_in = label_tab[img_addr[1:0]];
                    ld_cnt   = 0;
                end
            end else begin
                ld_cnt = 0;
            end
        end
    end

    // Core: step_done one cycle after step_go.
    initial begin
        bit pend = 1'b0;
        sd_auto = 1'b0;
        forever begin
            @(posedge clk); #1;
            sd_auto = pend;
            pend = step_go && core_en;
        end
    end

    // Decision block: valid_deciding dec_delay cycles into deciding; 0 means never.
    initial begin
        int dcnt = 0;
        vd_auto = 1'b0;
        forever begin
            @(posedge clk); #1;
            vd_auto = 1'b0;
            if (deciding && dec_delay > 0) begin
                dcnt++;
                if (dcnt == dec_delay) vd_auto = 1'b1;
            end else begin
                dcnt = 0;
            end
        end
    end

    // Monitor: every TU_incre / run_done is matched against the scoreboard head.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (TU_incre) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tu_event: unexpected TU_incre (label 0x%0h), required none", test_label);
                end else begin
                    e = exp_q.pop_front();
                    check("tu_event", {53'd0, 1'b0, done_core_img, coring, test_label},
                          {53'd0, e.is_run, e.done, 1'b1, e.label});
                end
            end
            if (run_done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL run_event: unexpected run_done (img_count %0d), required none", img_count);
                end else begin
                    e = exp_q.pop_front();
                    check("run_event", {44'd0, 1'b1, img_count, timeout_err, train_test_classify},
                          {44'd0, e.is_run, e.count, e.terr, e.mode});
                end
            end
            if (done_core_img && !TU_incre) begin
                n_cmp++; n_bad++;
                $display("FAIL done_align: done_core_img=1 with TU_incre=0, required both together");
            end
        end
    end

    initial begin
        int n, len;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
        num_images = '0; num_tu = '0; sd_force = 1'b0; vd_force = 1'b0;
        loader_en = 1'b1; core_en = 1'b1; dec_delay = 4;
        label_tab[0] = 8'h00; label_tab[1] = 8'h00; label_tab[2] = 8'h00; label_tab[3] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test mode, 2 images x 3 TU, labels 5 and 7.
        label_tab[0] = 8'd5; label_tab[1] = 8'd7;
        push_tu(0, 8'd5); push_tu(0, 8'd5); push_tu(1, 8'd5);
        push_tu(0, 8'd7); push_tu(0, 8'd7); push_tu(1, 8'd7);
        push_run(16'd2, 1'b0, 2'b10);
        start_run(2'b10, 16'd2, 16'd3);
        check("t1_accept", {56'd0, busy, img_req, img_addr[1:0], img_count[1:0], train_test_classify},
              {56'd0, 1'b1, 1'b1, 2'd0, 2'd0, 2'b10});
        wait_run_done("t1_run", 400);
        @(negedge clk);
        check("t1_idle", {47'd0, busy, img_count}, {47'd0, 1'b0, 16'd2});
        check("t1_queue", 64'(exp_q.size()), 64'd0);

        // Single TU, single image, train mode.
        label_tab[0] = 8'h2C;
        push_tu(1, 8'h2C); push_run(16'd1, 1'b0, 2'b01);
        start_run(2'b01, 16'd1, 16'd1);
        wait_run_done("t2_run", 200);
        @(negedge clk);
        check("t2_queue", 64'(exp_q.size()), 64'd0);

        // Decision never arrives: watchdog forces advance.
        dec_delay = 0;
        label_tab[0] = 8'd9; label_tab[1] = 8'd3;
        push_tu(1, 8'd9); push_tu(1, 8'd3); push_run(16'd2, 1'b1, 2'b11);
        start_run(2'b11, 16'd2, 16'd1);
        wait_deciding("t3_deciding", 100);
        len = 0;
        while (deciding && len < 200) begin
            @(negedge clk);
            len++;
        end
        check("t3_decide_len", 64'(len), 64'd64);
        check("t3_timeout_set", {63'd0, timeout_err}, 64'd1);
        wait_run_done("t3_run", 400);
        @(negedge clk);
        check("t3_queue", 64'(exp_q.size()), 64'd0);

        // Abort during the third time unit of image 1; mode 00 runs as train.
        dec_delay = 4;
        label_tab[0] = 8'h11; label_tab[1] = 8'h22; label_tab[2] = 8'h33;
        push_tu(0, 8'h11); push_tu(0, 8'h11); push_tu(1, 8'h11);
        push_tu(0, 8'h22); push_tu(0, 8'h22);
        start_run(2'b00, 16'd3, 16'd3);
        check("t4_accept", {44'd0, busy, img_req, timeout_err, img_count, train_test_classify},
              {44'd0, 1'b1, 1'b1, 1'b0, 16'd0, 2'b01});
        n = 0;
        for (int k = 0; k < 400 && n < 3; k++) begin
            if (step_go && img_addr == 16'd1) n++;
            if (n < 3) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_strobes", {56'd0, busy, img_req, step_go, coring, TU_incre, done_core_img, deciding, run_done},
              64'd0);
        check("t4_abort_held", {47'd0, img_count, timeout_err}, {47'd0, 16'd1, 1'b0});
        repeat (10) @(negedge clk);
        check("t4_stay_idle", {62'd0, busy, img_req}, 64'd0);
        check("t4_queue", 64'(exp_q.size()), 64'd0);

        // Zero counts are ignored, as is start while busy.
        start_run(2'b10, 16'd0, 16'd3);
        check("t5_zero_images", {62'd0, busy, img_req}, 64'd0);
        start_run(2'b10, 16'd1, 16'd0);
        check("t5_zero_tu", {62'd0, busy, img_req}, 64'd0);
        label_tab[0] = 8'h40;
        push_tu(0, 8'h40); push_tu(1, 8'h40); push_run(16'd1, 1'b0, 2'b10);
        start_run(2'b10, 16'd1, 16'd2);
        repeat (3) @(negedge clk);
        start_run(2'b11, 16'd5, 16'd4);
        check("t5_busy_start", {61'd0, busy, train_test_classify}, {61'd0, 1'b1, 2'b10});
        wait_run_done("t5_run", 200);
        @(negedge clk);
        check("t5_queue", 64'(exp_q.size()), 64'd0);

        // Reset while waiting in the second decision.
        label_tab[0] = 8'hA1; label_tab[1] = 8'hB2;
        push_tu(1, 8'hA1); push_tu(1, 8'hB2);
        start_run(2'b10, 16'd2, 16'd1);
        n = 0;
        while (img_count != 16'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        dec_delay = 0;
        wait_deciding("t6_deciding", 100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_reset", all_outs(), 64'd0);
        vd_force = 1'b1;
        @(negedge clk);
        vd_force = 1'b0;
        @(negedge clk);
        check("t6_stray_valid", all_outs(), 64'd0);
        check("t6_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
